// File: rtl/hwt_seq_pkg.sv
// Shared types and constants for the trojan-cone vector sequencer.
// Optional MISR signature output is enabled by defining HWT_SEQ_SIGNATURE_EN.
package hwt_seq_pkg;

  localparam int unsigned VEC_W = 4;
  localparam int unsigned SIG_W = 16;
  localparam int unsigned PCNT_W = 8;

  // Expected cone response for every {A,B,C,D}: Y = D & ((A & B) | C)
  localparam logic [15:0] GOLDEN_TT = 16'hA888;

  // MISR polynomial x^16 + x^12 + x^5 + 1 and its start value
  localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;
  localparam logic [SIG_W-1:0] MISR_SEED = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } seq_state_e;

  // Golden response lookup for one vector index
  function automatic logic golden_y(input logic [VEC_W-1:0] v);
    return GOLDEN_TT[v];
  endfunction

endpackage

// File: rtl/hwt_seq_misr.sv
// 16-bit signature register compacting the sampled cone responses.
module hwt_seq_misr
  import hwt_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_din,
  output logic [SIG_W-1:0] o_sig
);

  logic [SIG_W-1:0] r_sig;
  logic             w_fb;

  assign w_fb  = r_sig[SIG_W-1] ^ i_din;
  assign o_sig = r_sig;

  // Reseed on a new run, otherwise shift one response bit per sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= MISR_SEED;
    end else if (i_clr) begin
      r_sig <= MISR_SEED;
    end else if (i_shift) begin
      r_sig <= {r_sig[SIG_W-2:0], 1'b0} ^ ({SIG_W{w_fb}} & MISR_POLY);
    end
  end

endmodule

// File: rtl/hwt_vector_sequencer.sv
// Exhaustive self-test sequencer for the 4-input trojan-candidate cone.
// Define HWT_SEQ_SIGNATURE_EN to add the sig[15:0] MISR output.
module hwt_vector_sequencer
  import hwt_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned PASSES     = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             vec_a,
  output logic             vec_b,
  output logic             vec_c,
  output logic             vec_d,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_valid
`ifdef HWT_SEQ_SIGNATURE_EN
  ,
  output logic [SIG_W-1:0] sig
`endif
);

  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  seq_state_e        r_state;
  logic [VEC_W-1:0]  r_v;
  logic [PCNT_W-1:0] r_pass_cnt;
  logic [SET_W-1:0]  r_settle;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [CNT_W-1:0]  r_cnt;
  logic [VEC_W-1:0]  r_ffv;
  logic              r_ffvalid;

  logic              w_mis;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_last_vec;
  logic              w_last_pass;
  logic              w_settle_last;
  logic              w_accept;
  logic              w_abort_run;

  // Per-sample comparison and saturating count update
  assign w_mis         = y_in ^ golden_y(r_v);
  assign w_cnt_nxt     = (w_mis && (r_cnt != CNT_MAX)) ? r_cnt + CNT_W'(1) : r_cnt;
  assign w_last_vec    = (r_v == 4'hF);
  assign w_last_pass   = ((32'(r_pass_cnt) + 32'd1) >= PASSES);
  assign w_settle_last = ((32'(r_settle) + 32'd1) >= SETTLE_CYC);
  assign w_accept      = (r_state == IDLE) && start && !abort;
  assign w_abort_run   = (r_state != IDLE) && abort;

  assign {vec_a, vec_b, vec_c, vec_d} = r_v;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign mismatch_cnt     = r_cnt;
  assign first_fail_vec   = r_ffv;
  assign first_fail_valid = r_ffvalid;

  // Run sequencing: drive vector, settle, sample, repeat over all passes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_v        <= '0;
      r_pass_cnt <= '0;
      r_settle   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_cnt      <= '0;
      r_ffv      <= '0;
      r_ffvalid  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort_run) begin
        // Partial mismatch results stay visible after an abort
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_pass  <= 1'b0;
        r_v     <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_state    <= DRIVE;
              r_busy     <= 1'b1;
              r_pass     <= 1'b0;
              r_cnt      <= '0;
              r_ffvalid  <= 1'b0;
              r_v        <= '0;
              r_pass_cnt <= '0;
            end
          end
          DRIVE: begin
            r_settle <= '0;
            if (SETTLE_CYC == 0) begin
              r_state <= SAMPLE;
            end else begin
              r_state <= SETTLE;
            end
          end
          SETTLE: begin
            if (w_settle_last) begin
              r_state <= SAMPLE;
            end else begin
              r_settle <= r_settle + SET_W'(1);
            end
          end
          SAMPLE: begin
            r_cnt <= w_cnt_nxt;
            if (w_mis && !r_ffvalid) begin
              r_ffv     <= r_v;
              r_ffvalid <= 1'b1;
            end
            r_v     <= r_v + 4'd1;
            r_state <= DRIVE;
            if (w_last_vec) begin
              r_pass_cnt <= r_pass_cnt + 8'd1;
              if (w_last_pass) begin
                r_state <= DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_pass  <= (w_cnt_nxt == '0);
              end
            end
          end
          DONE: begin
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef HWT_SEQ_SIGNATURE_EN
  logic w_misr_shift;

  assign w_misr_shift = (r_state == SAMPLE) && !abort;

  hwt_seq_misr u_misr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_accept),
    .i_shift (w_misr_shift),
    .i_din   (y_in),
    .o_sig   (sig)
  );
`endif

endmodule

// File: tb/tb_hwt_vector_sequencer.sv
// Scoreboard bench for hwt_vector_sequencer: three instances with different
// parameters, each driven by a behavioural cone model.
module tb_hwt_vector_sequencer;

  typedef struct {
    int unsigned done_cyc;
    int unsigned cnt;
    logic [3:0]  ffv;
    logic        ffvalid;
    logic        pass;
  } exp_t;

  logic clk;
  logic rst_n;
  int unsigned cyc;
  int unsigned n_chk;
  int unsigned n_err;

  logic       start [3];
  logic       abort [3];
  logic [1:0] mode  [3];
  logic       va [3], vb [3], vc [3], vd [3];
  logic       y  [3];
  logic       busy [3], done [3], pass [3], ffvld [3];
  logic [3:0] ffv  [3];
  logic [3:0] vec  [3];
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic [7:0] cnt_x [3];
`ifdef HWT_SEQ_SIGNATURE_EN
  logic [15:0] sig [3];
`endif

  exp_t q [3][$];
  int unsigned lat [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign cnt_x[0] = cnt0;
  assign cnt_x[1] = cnt1;
  assign cnt_x[2] = {6'b0, cnt2};

  hwt_vector_sequencer #(.SETTLE_CYC(2), .PASSES(1), .CNT_W(8)) u_def (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .vec_a(va[0]), .vec_b(vb[0]), .vec_c(vc[0]), .vec_d(vd[0]), .y_in(y[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .mismatch_cnt(cnt0),
    .first_fail_vec(ffv[0]), .first_fail_valid(ffvld[0])
`ifdef HWT_SEQ_SIGNATURE_EN
    , .sig(sig[0])
`endif
  );

  hwt_vector_sequencer #(.SETTLE_CYC(2), .PASSES(2), .CNT_W(8)) u_p2 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .vec_a(va[1]), .vec_b(vb[1]), .vec_c(vc[1]), .vec_d(vd[1]), .y_in(y[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .mismatch_cnt(cnt1),
    .first_fail_vec(ffv[1]), .first_fail_valid(ffvld[1])
`ifdef HWT_SEQ_SIGNATURE_EN
    , .sig(sig[1])
`endif
  );

  hwt_vector_sequencer #(.SETTLE_CYC(0), .PASSES(1), .CNT_W(2)) u_fast (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]),
    .vec_a(va[2]), .vec_b(vb[2]), .vec_c(vc[2]), .vec_d(vd[2]), .y_in(y[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .mismatch_cnt(cnt2),
    .first_fail_vec(ffv[2]), .first_fail_valid(ffvld[2])
`ifdef HWT_SEQ_SIGNATURE_EN
    , .sig(sig[2])
`endif
  );

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Cone models and scoreboard monitors, one per instance
  for (genvar g = 0; g < 3; g++) begin : g_inst
    logic [3:0] prev_vec;
    logic [7:0] sweep;
    logic       gold;
    exp_t       e;

    assign vec[g] = {va[g], vb[g], vc[g], vd[g]};
    assign gold   = vec[g][0] & ((vec[g][3] & vec[g][2]) | vec[g][1]);
    assign y[g]   = (mode[g] == 2'd1) ? 1'b1 :
                    (mode[g] == 2'd2) ? ~gold :
                    (mode[g] == 2'd3) ? (gold ^ ((sweep == 8'd1) && (vec[g] == 4'd6))) :
                    gold;

    // Sweep count seen by the cone: a 15 -> 0 step while the run is live
    always @(posedge clk) begin
      prev_vec <= vec[g];
      if (start[g] && !busy[g]) sweep <= 8'd0;
      else if (busy[g] && prev_vec == 4'hF && vec[g] == 4'h0) sweep <= sweep + 8'd1;
    end

    always @(negedge clk) begin
      if (rst_n && done[g]) begin
        if (q[g].size() == 0) begin
          chk($sformatf("u%0d_unexpected_done", g), 1, 0);
        end else begin
          e = q[g].pop_front();
          chk($sformatf("u%0d_done_cycle", g), cyc, e.done_cyc);
          chk($sformatf("u%0d_mismatch_cnt", g), cnt_x[g], e.cnt);
          chk($sformatf("u%0d_pass", g), pass[g], e.pass);
          chk($sformatf("u%0d_busy_at_done", g), busy[g], 0);
          chk($sformatf("u%0d_ff_valid", g), ffvld[g], e.ffvalid);
          if (e.ffvalid) chk($sformatf("u%0d_ff_vec", g), ffv[g], e.ffv);
        end
      end
    end
  end

  // Issue a run request and queue its expected result
  task automatic issue(input int i, input logic [1:0] m, input int unsigned c,
                       input logic [3:0] fv, input logic fvld, input logic p);
    exp_t e;
    mode[i]    = m;
    start[i]   = 1'b1;
    e.done_cyc = cyc + 1 + lat[i];
    e.cnt      = c;
    e.ffv      = fv;
    e.ffvalid  = fvld;
    e.pass     = p;
    q[i].push_back(e);
  endtask

  task automatic drop_starts();
    @(negedge clk);
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
  endtask

  task automatic wait_all(input string nm);
    int n;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk({nm, "_timeout"}, (n >= 400) ? 1 : 0, 0);
  endtask

  task automatic chk_zero(input string nm);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_u%0d_outputs", nm, i),
          {busy[i], done[i], pass[i], ffvld[i], vec[i], ffv[i], cnt_x[i]}, 0);
`ifdef HWT_SEQ_SIGNATURE_EN
      chk($sformatf("%s_u%0d_sig", nm, i), sig[i], 16'hFFFF);
`endif
    end
  endtask

  initial begin
    int n;
    lat[0] = 64;
    lat[1] = 128;
    lat[2] = 32;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      abort[i] = 1'b0;
      mode[i]  = 2'd0;
    end
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Golden / delayed-trigger / inverted-with-saturation, in parallel
    issue(0, 2'd0, 0, 4'h0, 1'b0, 1'b1);
    issue(1, 2'd3, 1, 4'h6, 1'b1, 1'b0);
    issue(2, 2'd2, 3, 4'h0, 1'b1, 1'b0);
    drop_starts();
    repeat (10) @(negedge clk);
    start[0] = 1'b1;  // start while busy must be ignored
    drop_starts();
    wait_all("run1");

    // Stuck-at-1, golden over two passes, fast golden
    issue(0, 2'd1, 11, 4'h0, 1'b1, 1'b0);
    issue(1, 2'd0, 0, 4'h0, 1'b0, 1'b1);
    issue(2, 2'd0, 0, 4'h0, 1'b0, 1'b1);
    drop_starts();
    wait_all("run2");

    // Second-sweep trigger stays hidden with a single pass
    issue(0, 2'd3, 0, 4'h0, 1'b0, 1'b1);
    drop_starts();
    wait_all("run3");

    // start with abort in IDLE: no run
    start[0] = 1'b1;
    abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    abort[0] = 1'b0;
    chk("start_abort_idle_busy", busy[0], 0);

    // Abort during SETTLE of vector 5 on a stuck-at-1 cone
    mode[0]  = 2'd1;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while (vec[0] != 4'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_v5_timeout", (n >= 100) ? 1 : 0, 0);
    @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    chk("abort_busy", busy[0], 0);
    chk("abort_vec", vec[0], 0);
    chk("abort_pass", pass[0], 0);
    chk("abort_done", done[0], 0);
    chk("abort_partial_cnt", cnt0, 4);
    chk("abort_ff_valid", ffvld[0], 1);
    chk("abort_ff_vec", ffv[0], 0);
    repeat (80) @(negedge clk);
    chk("abort_idle_after", busy[0], 0);

    // Asynchronous reset in the middle of a sweep
    for (int i = 0; i < 3; i++) begin
      mode[i]  = 2'd1;
      start[i] = 1'b1;
    end
    drop_starts();
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Recovery run after reset
    issue(2, 2'd0, 0, 4'h0, 1'b0, 1'b1);
    drop_starts();
    wait_all("run4");

    for (int i = 0; i < 3; i++) chk($sformatf("u%0d_queue_empty", i), q[i].size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
